// File: rtl/cva5_types.sv
`default_nettype none
// ============================================================================
//  Module      : cva5_types (package)
//  Description : Shared types for the load response queue. Holds the RISC-V
//                load funct3 encodings and the tracked-load entry record.
//                The entry id field is sized for the widest supported ID;
//                users keep only the low ID_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package cva5_types;

    // Widest load ID any instance may use
    localparam int MAX_ID_W = 16;

    // Load funct3 encodings
    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;

    // One tracked load: issue info, returned data and its presence flag
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [2:0]          fn3;
        logic [1:0]          offset;
        logic [31:0]         data;
        logic                data_valid;
    } load_rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/load_response_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_response_queue_if
//  Description : Bundle of the load response queue's request, response,
//                writeback and status signals.
//    req_*      : load issue handshake (valid/ready, id, fn3, addr[1:0])
//    rsp_*      : in-order memory data return, never stalled
//    wb_*       : aligned writeback handshake (valid/ack, id, data)
//    flush      : discard all tracked loads
//    occupancy  : tracked entries plus responses still to be discarded
//    rsp_error  : sticky unexpected-response flag
//  Modports    : slave (the queue), master (the environment driving it)
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_response_queue_if #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 3
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [ID_W-1:0]  req_id;
    logic [2:0]       req_fn3;
    logic [1:0]       req_offset;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             wb_valid;
    logic             wb_ack;
    logic [ID_W-1:0]  wb_id;
    logic [31:0]      wb_data;
    logic             flush;
    logic [OCC_W-1:0] occupancy;
    logic             rsp_error;

    modport slave (
        input  req_valid, req_id, req_fn3, req_offset,
        input  rsp_valid, rsp_data, wb_ack, flush,
        output req_ready, wb_valid, wb_id, wb_data, occupancy, rsp_error
    );

    modport master (
        output req_valid, req_id, req_fn3, req_offset,
        output rsp_valid, rsp_data, wb_ack, flush,
        input  req_ready, wb_valid, wb_id, wb_data, occupancy, rsp_error
    );

endinterface
`default_nettype wire

// File: rtl/load_data_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_data_align
//  Description : Combinational extraction and sign/zero extension of a
//                loaded word according to the load funct3 and addr[1:0].
//    data_i     : raw 32-bit memory word
//    fn3_i      : load funct3
//    offset_i   : byte address within the word
//    aligned_o  : register-ready result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_data_align
    import cva5_types::*;
(
    input  wire logic [31:0] data_i,
    input  wire logic [2:0]  fn3_i,
    input  wire logic [1:0]  offset_i,
    output logic      [31:0] aligned_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = data_i[7:0];
        case (offset_i)
            2'd1:    sel_byte = data_i[15:8];
            2'd2:    sel_byte = data_i[23:16];
            2'd3:    sel_byte = data_i[31:24];
            default: sel_byte = data_i[7:0];
        endcase
        sel_half = offset_i[1] ? data_i[31:16] : data_i[15:0];

        case (fn3_i)
            FN3_LB:  aligned_o = {{24{sel_byte[7]}}, sel_byte};
            FN3_LBU: aligned_o = {24'h0, sel_byte};
            FN3_LH:  aligned_o = {{16{sel_half[15]}}, sel_half};
            FN3_LHU: aligned_o = {16'h0, sel_half};
            default: aligned_o = data_i;   // LW and any other code
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_response_queue.sv
`default_nettype none
// ============================================================================
//  Module      : load_response_queue
//  Description : Tracks issued loads until their in-order memory data returns,
//                then presents the aligned result for writeback in issue
//                order. Flushed loads still owed a response are remembered in
//                a discard counter so their late data is silently dropped.
//    clk        : clock
//    rst        : asynchronous active-low reset
//    bus        : load_response_queue_if.slave (request, response,
//                 writeback, flush, occupancy, rsp_error)
//  Build macro : LOAD_RSP_BYPASS_EN - response to the waiting head entry is
//                presented for writeback in the same cycle it arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_response_queue
    import cva5_types::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    load_response_queue_if.slave  bus
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    load_rsp_entry_t  entries_q [DEPTH];
    load_rsp_entry_t  entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] dat_ptr_q, dat_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;     // occupied entries
    logic [CNT_W-1:0] pend_q,    pend_d;      // occupied entries still without data
    logic [CNT_W-1:0] discard_q, discard_d;   // responses owed to flushed loads
    logic             rsp_error_q, rsp_error_d;

    load_rsp_entry_t  head;
    logic [CNT_W-1:0] occ;
    logic             req_ready;
    logic             push;
    logic             rsp_discard;
    logic             rsp_fill;
    logic             rsp_orphan;
    logic             bypass;
    logic             wb_valid;
    logic             pop;
    logic [31:0]      align_src;
    logic [31:0]      align_out;

    assign head = entries_q[rd_ptr_q];

    always_comb begin
        occ       = count_q + discard_q;
        // Ready uses pre-pop occupancy, so a full queue never passes a push
        // through a same-cycle pop.
        req_ready = rst & ~bus.flush & (occ < FULL_CNT);
        push      = bus.req_valid & req_ready;

        // Late data for flushed loads is consumed before any live entry.
        rsp_discard = bus.rsp_valid & (discard_q != '0);
        rsp_fill    = bus.rsp_valid & (discard_q == '0) & (pend_q != '0);
        rsp_orphan  = bus.rsp_valid & (discard_q == '0) & (pend_q == '0);

`ifdef LOAD_RSP_BYPASS_EN
        // dat_ptr == rd_ptr with data owed means the head itself is waiting
        bypass = rsp_fill & (dat_ptr_q == rd_ptr_q);
`else
        bypass = 1'b0;
`endif

        wb_valid  = head.data_valid | bypass;
        pop       = wb_valid & bus.wb_ack;
        align_src = bypass ? bus.rsp_data : head.data;
    end

    load_data_align u_align (
        .data_i    (align_src),
        .fn3_i     (head.fn3),
        .offset_i  (head.offset),
        .aligned_o (align_out)
    );

    always_comb begin
        entries_d   = entries_q;
        wr_ptr_d    = wr_ptr_q;
        dat_ptr_d   = dat_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        pend_d      = pend_q + CNT_W'(push) - CNT_W'(rsp_fill);
        discard_d   = discard_q - CNT_W'(rsp_discard);
        rsp_error_d = rsp_error_q | rsp_orphan;

        if (push) begin
            entries_d[wr_ptr_q].id         = MAX_ID_W'(bus.req_id);
            entries_d[wr_ptr_q].fn3        = bus.req_fn3;
            entries_d[wr_ptr_q].offset     = bus.req_offset;
            entries_d[wr_ptr_q].data       = 32'h0;
            entries_d[wr_ptr_q].data_valid = 1'b0;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (rsp_fill) begin
            entries_d[dat_ptr_q].data       = bus.rsp_data;
            entries_d[dat_ptr_q].data_valid = 1'b1;
            dat_ptr_d = dat_ptr_q + PTR_W'(1);
        end

        // Applied after the fill so a bypassed-and-acked head ends up empty.
        if (pop) begin
            entries_d[rd_ptr_q].data_valid = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (bus.flush) begin
            // Entries whose data is still owed become discards; one filled
            // this very cycle is no longer owed.
            discard_d = discard_q - CNT_W'(rsp_discard) + (pend_q - CNT_W'(rsp_fill));
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].data_valid = 1'b0;
            end
            wr_ptr_d  = '0;
            dat_ptr_d = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pend_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            dat_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            discard_q   <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            wr_ptr_q    <= wr_ptr_d;
            dat_ptr_q   <= dat_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            discard_q   <= discard_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_id     = head.id[ID_W-1:0];
    assign bus.wb_data   = align_out;
    assign bus.occupancy = occ;
    assign bus.rsp_error = rsp_error_q;

endmodule
`default_nettype wire
